// File: rtl/sd_access_sched_if.sv
// sd_access_sched_if: requester side and SD engine side
// signals of the SD access scheduler in one bundle.
interface sd_access_sched_if;
    logic [1:0]  req;
    logic [1:0]  req_wr;
    logic [31:0] req_addr0;
    logic [31:0] req_addr1;
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic        err;
    logic        sd_init;
    logic        init_ok;
    logic        blk_start;
    logic        blk_wr;
    logic [31:0] blk_addr;
    logic        blk_done;
    logic        blk_err;
    logic        sd_ready;
    logic        init_fail;

    modport master (
        output req, req_wr, req_addr0, req_addr1,
        output init_ok, blk_done, blk_err,
        input  gnt, done, err, sd_init, blk_start,
        input  blk_wr, blk_addr, sd_ready, init_fail
    );

    modport slave (
        input  req, req_wr, req_addr0, req_addr1,
        input  init_ok, blk_done, blk_err,
        output gnt, done, err, sd_init, blk_start,
        output blk_wr, blk_addr, sd_ready, init_fail
    );
endinterface

// File: rtl/sd_access_sched.sv
// sd_access_sched: SD card bring-up sequencer with retry, and
// round-robin single-block op arbiter for two requesters.
module sd_access_sched #(
    parameter int INIT_TMO   = 100000,
    parameter int INIT_RETRY = 3,
    parameter int OP_TMO     = 500000
) (
    input  logic             clk,
    input  logic             rst_n,
    sd_access_sched_if.slave bus
);

    localparam int MAXT = (INIT_TMO > OP_TMO) ? INIT_TMO : OP_TMO;
    localparam int TW   = $clog2(MAXT);
    localparam int CW   = (INIT_RETRY > 1) ? $clog2(INIT_RETRY) : 1;

    localparam logic [TW-1:0] INIT_LAST = TW'(INIT_TMO - 1);
    localparam logic [TW-1:0] OP_LAST   = TW'(OP_TMO - 1);
    localparam logic [CW-1:0] TRY_LAST  = CW'(INIT_RETRY - 1);

    typedef enum logic [2:0] {
        RST, INIT, IWAIT, READY, ISSUE, BUSY, FAIL
    } state_t;

    state_t        state, state_nx;
    logic [TW-1:0] timer, timer_nx;
    logic [CW-1:0] rcnt, rcnt_nx;
    logic          rr, rr_nx;
    logic          win, win_nx;
    logic          wr_q, wr_nx;
    logic [31:0]   addr_q, addr_nx;
    logic          pick;
    logic          fin;

    // Winner: round-robin pointer on contention, else the lone requester
    always_comb begin
        pick = (bus.req == 2'b11) ? rr : bus.req[1];
    end

    // State and op-context registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= RST;
            timer  <= '0;
            rcnt   <= '0;
            rr     <= 1'b0;
            win    <= 1'b0;
            wr_q   <= 1'b0;
            addr_q <= '0;
        end else begin
            state  <= state_nx;
            timer  <= timer_nx;
            rcnt   <= rcnt_nx;
            rr     <= rr_nx;
            win    <= win_nx;
            wr_q   <= wr_nx;
            addr_q <= addr_nx;
        end
    end

    // Next state, timers, arbitration and completion pulse
    always_comb begin
        state_nx = state;
        timer_nx = timer;
        rcnt_nx  = rcnt;
        rr_nx    = rr;
        win_nx   = win;
        wr_nx    = wr_q;
        addr_nx  = addr_q;
        fin      = 1'b0;
        bus.err  = 1'b0;
        unique case (state)
            RST: state_nx = INIT;
            INIT: begin
                timer_nx = '0;
                state_nx = IWAIT;
            end
            IWAIT: begin
                timer_nx = timer + 1'b1;
                if (bus.init_ok) begin
                    rcnt_nx  = '0;
                    state_nx = READY;
                end else if (timer == INIT_LAST) begin
                    rcnt_nx  = rcnt + 1'b1;
                    state_nx = (rcnt == TRY_LAST) ? FAIL : INIT;
                end
            end
            READY: begin
                if (!bus.init_ok) begin
                    state_nx = INIT;
                end else if (bus.req != 2'b00) begin
                    win_nx   = pick;
                    rr_nx    = ~pick;
                    wr_nx    = bus.req_wr[pick];
                    addr_nx  = pick ? bus.req_addr1 : bus.req_addr0;
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                timer_nx = '0;
                state_nx = BUSY;
            end
            BUSY: begin
                timer_nx = timer + 1'b1;
                if (bus.blk_done) begin
                    fin      = 1'b1;
                    bus.err  = bus.blk_err;
                    state_nx = READY;
                end else if (timer == OP_LAST) begin
                    // Engine hung: report failure and re-init the card
                    fin      = 1'b1;
                    bus.err  = 1'b1;
                    rcnt_nx  = '0;
                    state_nx = INIT;
                end
            end
            FAIL: state_nx = FAIL;
            default: state_nx = RST;
        endcase
    end

    // State-decoded outputs; op context held from issue to done
    always_comb begin
        bus.gnt = 2'b00;
        if (state == ISSUE || state == BUSY) begin
            bus.gnt = win ? 2'b10 : 2'b01;
        end
        bus.done      = fin ? bus.gnt : 2'b00;
        bus.sd_init   = (state == INIT);
        bus.blk_start = (state == ISSUE);
        bus.sd_ready  = (state == READY) || (state == ISSUE) ||
                        (state == BUSY);
        bus.init_fail = (state == FAIL);
        bus.blk_wr    = wr_q;
        bus.blk_addr  = addr_q;
    end

endmodule

// File: tb/tb_sd_access_sched.sv
// tb_sd_access_sched: directed bring-up/arbitration scenarios plus
// random traffic, all checked against a cycle model of the rules.
module tb_sd_access_sched;

    localparam int INIT_TMO   = 16;
    localparam int INIT_RETRY = 3;
    localparam int OP_TMO     = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    sd_access_sched_if bus ();

    sd_access_sched #(
        .INIT_TMO  (INIT_TMO),
        .INIT_RETRY(INIT_RETRY),
        .OP_TMO    (OP_TMO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int init_pulses = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference model: what the scheduler must be doing this cycle
    bit          m_pulse;   // sd_init due this cycle
    int          m_wait;    // cycles spent waiting for init_ok, -1 idle
    int          m_tries;   // failed init attempts so far
    bit          m_dead;
    bit          m_up;      // card usable
    int          m_op;      // -1 none, 0 start cycle, n = n-th busy cycle
    logic        m_who;
    logic        m_rr;
    logic        m_wr;
    logic [31:0] m_addr;

    initial begin
        bit          fin;
        logic [1:0]  e_gnt;
        logic        who;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_out", {bus.gnt, bus.done, bus.err, bus.sd_init,
                    bus.blk_start, bus.sd_ready, bus.init_fail}, 0);
                // first edge after release leaves the reset cycle
                m_pulse = 1; m_wait = -1; m_tries = 0; m_dead = 0;
                m_up = 0; m_op = -1; m_rr = 0; m_who = 0;
                continue;
            end
            if (bus.sd_init) init_pulses++;
            fin   = (m_op >= 1) && (bus.blk_done || m_op == OP_TMO);
            e_gnt = (m_op >= 0) ? (m_who ? 2'b10 : 2'b01) : 2'b00;
            chk("sd_init", bus.sd_init, m_pulse);
            chk("sd_ready", bus.sd_ready, m_up);
            chk("init_fail", bus.init_fail, m_dead);
            chk("blk_start", bus.blk_start, m_op == 0);
            chk("gnt", bus.gnt, e_gnt);
            chk("done", bus.done, fin ? e_gnt : 2'b00);
            if (fin) chk("err", bus.err, bus.blk_done ? bus.blk_err : 1'b1);
            if (m_op >= 0) begin
                chk("blk_addr", bus.blk_addr, m_addr);
                chk("blk_wr", bus.blk_wr, m_wr);
            end
            if (m_dead) begin
            end else if (m_pulse) begin
                m_pulse = 0; m_wait = 0;
            end else if (m_wait >= 0) begin
                if (bus.init_ok) begin
                    m_wait = -1; m_up = 1; m_tries = 0;
                end else if (m_wait == INIT_TMO - 1) begin
                    m_wait = -1; m_tries++;
                    if (m_tries < INIT_RETRY) m_pulse = 1;
                    else m_dead = 1;
                end else m_wait++;
            end else if (m_up) begin
                if (fin) begin
                    m_op = -1;
                    if (!bus.blk_done) begin
                        m_up = 0; m_pulse = 1; m_tries = 0;
                    end
                end else if (m_op >= 0) m_op++;
                else if (!bus.init_ok) begin
                    m_up = 0; m_pulse = 1;
                end else if (bus.req != 2'b00) begin
                    who    = (bus.req == 2'b11) ? m_rr : bus.req[1];
                    m_rr   = ~who;
                    m_who  = who;
                    m_wr   = bus.req_wr[who];
                    m_addr = who ? bus.req_addr1 : bus.req_addr0;
                    m_op   = 0;
                end
            end
        end
    end

    task automatic reset_dut();
        rst_n = 1'b0;
        bus.req = 0; bus.req_wr = 0; bus.req_addr0 = 0; bus.req_addr1 = 0;
        bus.init_ok = 0; bus.blk_done = 0; bus.blk_err = 0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic wait_sig(input string nm, input int which, input int lim);
        bit seen = 0;
        for (int i = 0; i < lim && !seen; i++) begin
            @(negedge clk);
            case (which)
                0: seen = bus.sd_init;
                1: seen = bus.sd_ready;
                default: seen = bus.blk_start;
            endcase
        end
        chk(nm, seen, 1);
    endtask

    // Serve one op: wait for blk_start, finish it on busy cycle dly
    task automatic run_op(input int dly, input logic e, input bit drop,
                          output logic [1:0] g, output logic [31:0] a,
                          output logic w, output logic [1:0] d,
                          output logic er, output logic rdy);
        wait_sig("op_start", 2, 40);
        g = bus.gnt; a = bus.blk_addr; w = bus.blk_wr;
        repeat (dly) begin @(posedge clk); #1; end
        bus.blk_done = 1; bus.blk_err = e;
        if (drop) bus.req = 0;
        @(negedge clk);
        d = bus.done; er = bus.err; rdy = bus.sd_ready;
        @(posedge clk); #1;
        bus.blk_done = 0; bus.blk_err = 0;
    endtask

    initial begin
        logic [1:0]  g, d;
        logic [31:0] a;
        logic        w, er, rdy;
        int          base, np, fc, n;
        int          pc [4];
        bit          saw_init, failed;
        int          ok_dly;

        // Bring-up: init_ok 10 cycles after the pulse
        reset_dut();
        base = init_pulses;
        wait_sig("t1_init_seen", 0, 8);
        repeat (10) begin @(posedge clk); #1; end
        bus.init_ok = 1;
        @(negedge clk); chk("t1_rdy_early", bus.sd_ready, 0);
        @(negedge clk); chk("t1_rdy", bus.sd_ready, 1);
        chk("t1_pulses", init_pulses - base, 1);

        // Contention alternates grants
        @(posedge clk); #1;
        bus.req = 2'b11; bus.req_wr = 2'b00;
        bus.req_addr0 = 32'h10; bus.req_addr1 = 32'h20;
        run_op(2, 0, 0, g, a, w, d, er, rdy);
        chk("t3_g0", g, 2'b01); chk("t3_a0", a, 32'h10);
        run_op(4, 0, 0, g, a, w, d, er, rdy);
        chk("t3_g1", g, 2'b10); chk("t3_a1", a, 32'h20);
        run_op(1, 0, 1, g, a, w, d, er, rdy);
        chk("t3_g2", g, 2'b01); chk("t3_a2", a, 32'h10);

        // Write with engine error
        bus.req = 2'b01; bus.req_wr = 2'b01; bus.req_addr0 = 32'h5;
        run_op(3, 1, 1, g, a, w, d, er, rdy);
        chk("t4_addr", a, 32'h5); chk("t4_wr", w, 1);
        chk("t4_done", d, 2'b01); chk("t4_err", er, 1);
        chk("t4_rdy", rdy, 1);

        // Engine never answers: timeout then re-init
        bus.req = 2'b10; bus.req_wr = 2'b00; bus.req_addr1 = 32'h77;
        wait_sig("t5_start", 2, 10);
        n = 0;
        for (int i = 1; i <= 40 && n == 0; i++) begin
            @(negedge clk);
            if (bus.done != 2'b00) begin
                n = i; d = bus.done; er = bus.err;
            end
        end
        chk("t5_cycle", n, OP_TMO);
        chk("t5_done", d, 2'b10); chk("t5_err", er, 1);
        @(posedge clk); #1; bus.req = 0;
        @(negedge clk);
        chk("t5_reinit", bus.sd_init, 1); chk("t5_rdy", bus.sd_ready, 0);

        // Asynchronous reset while busy
        wait_sig("t6_ready", 1, 10);
        @(posedge clk); #1; bus.req = 2'b01;
        wait_sig("t6_start", 2, 10);
        @(posedge clk); #3;
        chk("t6_gnt_pre", bus.gnt, 2'b01);
        rst_n = 0; #1;
        chk("t6_gnt", bus.gnt, 0); chk("t6_start0", bus.blk_start, 0);
        chk("t6_rdy", bus.sd_ready, 0); chk("t6_done", bus.done, 0);
        reset_dut();
        wait_sig("t6_restart", 0, 4);

        // Card never initialises: three attempts then failure
        reset_dut();
        np = 0; fc = -1;
        foreach (pc[i]) pc[i] = 0;
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            if (bus.sd_init && np < 4) begin pc[np] = c; np++; end
            if (bus.init_fail && fc < 0) fc = c;
        end
        chk("t2_pulses", np, INIT_RETRY);
        // one INIT cycle plus INIT_TMO waiting cycles per attempt
        chk("t2_gap0", pc[1] - pc[0], INIT_TMO + 1);
        chk("t2_gap1", pc[2] - pc[1], INIT_TMO + 1);
        chk("t2_fail_at", fc - pc[2], INIT_TMO + 1);
        chk("t2_rdy", bus.sd_ready, 0);
        @(posedge clk); #1; bus.req = 2'b11; bus.init_ok = 1;
        repeat (5) @(negedge clk);
        chk("t2_no_gnt", bus.gnt, 0);

        // Random traffic against the model
        reset_dut();
        ok_dly = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            saw_init = bus.sd_init; failed = bus.init_fail;
            @(posedge clk); #1;
            if (failed) begin
                reset_dut(); ok_dly = 0;
                continue;
            end
            if (saw_init) begin
                bus.init_ok = 0; ok_dly = $urandom_range(1, 20);
            end else if (ok_dly > 0) begin
                ok_dly--;
                if (ok_dly == 0) bus.init_ok = 1;
            end else if (bus.init_ok && $urandom_range(0, 299) == 0) begin
                bus.init_ok = 0;
            end
            bus.req       = 2'($urandom_range(0, 3));
            bus.req_wr    = 2'($urandom_range(0, 3));
            bus.req_addr0 = $urandom;
            bus.req_addr1 = $urandom;
            bus.blk_done  = ($urandom_range(0, 9) == 0);
            bus.blk_err   = 1'($urandom_range(0, 1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
